// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit and any other producer of the
// ALU_Flags bus: opcodes, flag bit positions and the sequencer state encoding.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_CMP = 3'd5;
   localparam logic [2:0] OP_SHL = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational {Z,N,V} generator for a finished ALU result. Overflow is only
// meaningful for add/subtract; logic, shift and multiply report V=0.
module alu_flag_gen
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] r,
   output logic [2:0]       flags
);

   // Only the sign bits of the operands matter for overflow.
   logic unused_low_bits;
   assign unused_low_bits = ^{a[WIDTH-2:0], b[WIDTH-2:0]};

   always_comb begin
      flags         = '0;
      flags[FLAG_Z] = (r == '0);
      flags[FLAG_N] = r[WIDTH-1];
      case (op)
         OP_ADD:         flags[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         OP_SUB, OP_CMP: flags[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         default:        flags[FLAG_V] = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_flags_unit.sv
// ALU execution unit: logic/add ops finish in one cycle, SHL and MUL iterate one
// bit per cycle. Result and {Z,N,V} are registered only when an op completes.
module alu_flags_unit
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             set_flags,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       alu_flags
);

   localparam logic [SHAMT_W:0] MUL_STEPS = (SHAMT_W+1)'(WIDTH);
   localparam logic [SHAMT_W:0] CNT_ONE   = (SHAMT_W+1)'(1);

   state_t             state, state_nxt;
   logic [SHAMT_W:0]   cnt;
   logic [2:0]         op_q;
   logic               set_flags_q;
   logic [WIDTH-1:0]   acc, mcand, mplier;
   logic [WIDTH-1:0]   quick_r, step_acc;
   logic [SHAMT_W-1:0] shamt;
   logic               multi_cycle, accept, last_step, commit;
   logic [2:0]         fin_op;
   logic [WIDTH-1:0]   fin_a, fin_b, fin_r;
   logic               fin_set;
   logic [2:0]         fin_flags;

   assign shamt       = b[SHAMT_W-1:0];
   assign multi_cycle = (op == OP_MUL) || ((op == OP_SHL) && (shamt != '0));
   assign accept      = (state == ST_IDLE) && start;
   assign last_step   = (state == ST_EXEC) && (cnt == CNT_ONE);
   assign commit      = (accept && !multi_cycle) || last_step;
   assign busy        = (state == ST_EXEC);
   assign done        = (state == ST_DONE);

   // Single-cycle results; SHL by zero simply passes A through.
   always_comb begin
      quick_r = a;
      case (op)
         OP_ADD:         quick_r = a + b;
         OP_SUB, OP_CMP: quick_r = a - b;
         OP_AND:         quick_r = a & b;
         OP_OR:          quick_r = a | b;
         OP_XOR:         quick_r = a ^ b;
         default:        quick_r = a;
      endcase
   end

   // One iteration of shift-left or shift-add multiply.
   always_comb begin
      step_acc = acc << 1;
      if (op_q == OP_MUL) begin
         step_acc = mplier[0] ? (acc + mcand) : acc;
      end
   end

   // The completing op is either the one arriving now or the iterative one ending
   // this cycle, whose final value is the accumulator after its last step.
   always_comb begin
      fin_op  = op;
      fin_a   = a;
      fin_b   = b;
      fin_r   = quick_r;
      fin_set = set_flags;
      if (state != ST_IDLE) begin
         fin_op  = op_q;
         fin_a   = mcand;
         fin_b   = mplier;
         fin_r   = step_acc;
         fin_set = set_flags_q;
      end
   end

   alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
      .op    (fin_op),
      .a     (fin_a),
      .b     (fin_b),
      .r     (fin_r),
      .flags (fin_flags)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = multi_cycle ? ST_EXEC : ST_DONE;
         ST_EXEC: if (cnt == CNT_ONE) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Operand latch, iteration counter and accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q        <= OP_ADD;
         set_flags_q <= 1'b0;
         acc         <= '0;
         mcand       <= '0;
         mplier      <= '0;
         cnt         <= '0;
      end else if (accept) begin
         op_q        <= op;
         set_flags_q <= set_flags;
         mcand       <= a;
         mplier      <= b;
         if (op == OP_MUL) begin
            acc <= '0;
            cnt <= MUL_STEPS;
         end else begin
            acc <= a;
            cnt <= {1'b0, shamt};
         end
      end else if (state == ST_EXEC) begin
         acc    <= step_acc;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - CNT_ONE;
      end
   end

   // Architectural outputs change only on completion; CMP never touches result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result    <= '0;
         alu_flags <= 3'b000;
      end else if (commit) begin
         if (fin_op != OP_CMP)              result    <= fin_r;
         if (fin_set || (fin_op == OP_CMP)) alu_flags <= fin_flags;
      end
   end

endmodule
